// File: rtl/hft_sched_pkg.sv
// rtl/hft_sched_pkg.sv - shared types and default limits for the order execution scheduler
package hft_sched_pkg;

    typedef struct packed {
        logic [31:0] price;
        logic [31:0] qty;
        logic        side;
        logic [7:0]  reason;
    } order_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ISSUE
    } sched_state_e;

    localparam longint DEF_POS_LIMIT  = 1000000;
    localparam int     DEF_MAX_TOKENS = 8;

endpackage

// File: rtl/order_exec_scheduler_if.sv
// rtl/order_exec_scheduler_if.sv - engine/execution-port bundle; out_seq exists only with ORDER_SEQ_NUM_EN
interface order_exec_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int POS_W   = 40,
    parameter int TOK_W   = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_price;
    logic [NUM_REQ*32-1:0] req_qty;
    logic [NUM_REQ-1:0]    req_side;
    logic [NUM_REQ*8-1:0]  req_reason;
    logic                  halt;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_price;
    logic [31:0]           out_qty;
    logic                  out_side;
    logic [7:0]            out_reason;
    logic [ID_W-1:0]       out_src;
    logic                  reject_valid;
    logic [ID_W-1:0]       reject_src;
    logic [POS_W-1:0]      net_position;
    logic [TOK_W-1:0]      tokens_avail;
    logic                  busy;
`ifdef ORDER_SEQ_NUM_EN
    logic [15:0]           out_seq;
`endif

    modport master (
        input  req_valid, req_price, req_qty, req_side, req_reason, halt, out_ready,
`ifdef ORDER_SEQ_NUM_EN
        output out_seq,
`endif
        output req_ready, out_valid, out_price, out_qty, out_side, out_reason, out_src,
        output reject_valid, reject_src, net_position, tokens_avail, busy
    );

    modport slave (
        output req_valid, req_price, req_qty, req_side, req_reason, halt, out_ready,
`ifdef ORDER_SEQ_NUM_EN
        input  out_seq,
`endif
        input  req_ready, out_valid, out_price, out_qty, out_side, out_reason, out_src,
        input  reject_valid, reject_src, net_position, tokens_avail, busy
    );

endinterface

// File: rtl/order_exec_scheduler_rr_arbiter.sv
// rtl/order_exec_scheduler_rr_arbiter.sv - rotating-priority one-hot arbiter
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] cand;

    // Scan from the pointer upward with wrap; first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/order_exec_scheduler.sv
// rtl/order_exec_scheduler.sv - round-robin order scheduler with token-bucket and position limits
// Optional sequence numbering on out_seq when ORDER_SEQ_NUM_EN is defined.
module order_exec_scheduler
    import hft_sched_pkg::*;
#(
    parameter int     NUM_REQ       = 4,
    parameter int     ID_W          = 2,
    parameter int     POS_W         = 40,
    parameter longint POS_LIMIT     = DEF_POS_LIMIT,
    parameter int     MAX_TOKENS    = DEF_MAX_TOKENS,
    parameter int     REFILL_CYCLES = 1000
) (
    input logic clk,
    input logic rst_n,
    order_exec_scheduler_if.master bus
);
    localparam int TOK_W = $clog2(MAX_TOKENS + 1);
    localparam int RC_W  = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
    localparam logic signed [POS_W:0] LIM_P = (POS_W+1)'(POS_LIMIT);
    localparam logic signed [POS_W:0] LIM_N = -LIM_P;

    sched_state_e        state, state_nxt;
    order_t              cap, win_order;
    logic [ID_W-1:0]     rr_ptr, cap_src, win_idx;
    logic [NUM_REQ-1:0]  win_grant;
    logic                win_any;
    logic [POS_W-1:0]    pos;
    logic [TOK_W-1:0]    tokens;
    logic [RC_W-1:0]     refill_cnt;
    logic signed [POS_W:0] pos_ext, qty_ext, proj;
    logic                grant_en, reject, handshake, refill_wrap;

    rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    always_comb begin
        win_order = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_grant[i]) begin
                win_order = '{price:  bus.req_price[i*32 +: 32],
                              qty:    bus.req_qty[i*32 +: 32],
                              side:   bus.req_side[i],
                              reason: bus.req_reason[i*8 +: 8]};
            end
        end
    end

    assign grant_en    = (state == IDLE) && !bus.halt && (tokens != '0) && win_any;
    assign handshake   = (state == ISSUE) && bus.out_ready;
    assign refill_wrap = (refill_cnt == RC_W'(REFILL_CYCLES - 1));

    // One extra bit of headroom so the projection cannot wrap before the limit compare.
    assign pos_ext = {pos[POS_W-1], pos};
    assign qty_ext = {{(POS_W-31){1'b0}}, cap.qty};
    assign proj    = cap.side ? (pos_ext - qty_ext) : (pos_ext + qty_ext);
    assign reject  = (state == CHECK) && ((cap.qty == '0) || (proj > LIM_P) || (proj < LIM_N));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_en) state_nxt = CHECK;
            CHECK:   state_nxt = reject ? IDLE : ISSUE;
            ISSUE:   if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cap        <= '0;
            cap_src    <= '0;
            rr_ptr     <= '0;
            pos        <= '0;
            tokens     <= TOK_W'(MAX_TOKENS);
            refill_cnt <= '0;
        end else begin
            state      <= state_nxt;
            refill_cnt <= refill_wrap ? '0 : refill_cnt + 1'b1;
            if (grant_en) begin
                cap     <= win_order;
                cap_src <= win_idx;
                rr_ptr  <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
            if (handshake) pos <= proj[POS_W-1:0];
            // A refill landing on a consume cancels out, even when the bucket is full.
            if (handshake && !refill_wrap)
                tokens <= tokens - 1'b1;
            else if (refill_wrap && !handshake && (tokens != TOK_W'(MAX_TOKENS)))
                tokens <= tokens + 1'b1;
        end
    end

    assign bus.req_ready    = grant_en ? win_grant : '0;
    assign bus.out_valid    = (state == ISSUE);
    assign bus.out_price    = cap.price;
    assign bus.out_qty      = cap.qty;
    assign bus.out_side     = cap.side;
    assign bus.out_reason   = cap.reason;
    assign bus.out_src      = cap_src;
    assign bus.reject_valid = reject;
    assign bus.reject_src   = cap_src;
    assign bus.net_position = pos;
    assign bus.tokens_avail = tokens;
    assign bus.busy         = (state != IDLE);

`ifdef ORDER_SEQ_NUM_EN
    logic [15:0] seq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         seq <= '0;
        else if (handshake) seq <= seq + 16'd1;
    end

    assign bus.out_seq = seq;
`endif

endmodule

// File: tb/tb_order_exec_scheduler.sv
// tb/tb_order_exec_scheduler.sv - directed and random checks of order_exec_scheduler against a reference model
module tb_order_exec_scheduler;
    localparam int     N    = 4;
    localparam int     IW   = 2;
    localparam int     PW   = 40;
    localparam int     MAXT = 8;
    localparam int     RC   = 50;
    localparam longint LIM  = 1000000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails  = 0;
    logic [N-1:0] granted_last = '0;

    int          m_phase, m_ptr, m_tok, m_ref, m_src, m_seq;
    longint      m_pos;
    logic [31:0] m_price, m_qty;
    logic        m_side;
    logic [7:0]  m_reason;

    always #5 clk = ~clk;

    order_exec_scheduler_if #(.NUM_REQ(N), .ID_W(IW), .POS_W(PW), .TOK_W(4)) bus ();

    order_exec_scheduler #(
        .NUM_REQ(N), .ID_W(IW), .POS_W(PW), .POS_LIMIT(LIM),
        .MAX_TOKENS(MAXT), .REFILL_CYCLES(RC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_phase = 0; m_ptr = 0; m_tok = MAXT; m_ref = 0; m_src = 0; m_seq = 0;
        m_pos = 0; m_price = '0; m_qty = '0; m_side = 1'b0; m_reason = '0;
    endfunction

    // Reference: an order moves wait -> check -> issue, one step per cycle.
    always @(negedge clk) begin : model_check
        int win;
        longint q, proj;
        bit rej, hs, wrap;
        logic [N-1:0] exp_ready;
        if (!rst_n) begin
            model_reset();
            granted_last = '0;
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_tokens", bus.tokens_avail, MAXT);
            chk("rst_net_position", $signed(bus.net_position), 0);
            chk("rst_busy", bus.busy, 0);
        end else begin
            win = -1;
            if (m_phase == 0 && !bus.halt && m_tok > 0)
                for (int k = 0; k < N; k++)
                    if (win < 0 && bus.req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            exp_ready = '0;
            if (win >= 0) exp_ready[win] = 1'b1;
            q    = m_qty;
            proj = m_side ? m_pos - q : m_pos + q;
            rej  = (m_phase == 1) && (m_qty == 0 || proj > LIM || proj < -LIM);

            chk("req_ready", bus.req_ready, exp_ready);
            chk("out_valid", bus.out_valid, m_phase == 2);
            chk("busy", bus.busy, m_phase != 0);
            chk("reject_valid", bus.reject_valid, rej);
            chk("net_position", $signed(bus.net_position), m_pos);
            chk("tokens_avail", bus.tokens_avail, m_tok);
            if (rej) chk("reject_src", bus.reject_src, m_src);
            if (m_phase == 2) begin
                chk("out_price", bus.out_price, m_price);
                chk("out_qty", bus.out_qty, m_qty);
                chk("out_side", bus.out_side, m_side);
                chk("out_reason", bus.out_reason, m_reason);
                chk("out_src", bus.out_src, m_src);
`ifdef ORDER_SEQ_NUM_EN
                chk("out_seq", bus.out_seq, m_seq);
`endif
            end

            wrap  = (m_ref == RC - 1);
            m_ref = wrap ? 0 : m_ref + 1;
            hs    = (m_phase == 2) && bus.out_ready;
            if (hs && !wrap) m_tok--;
            else if (wrap && !hs && m_tok < MAXT) m_tok++;
            if (hs) begin
                m_pos = proj;
                m_seq = (m_seq + 1) % 65536;
            end
            case (m_phase)
                0: if (win >= 0) begin
                    m_phase  = 1;
                    m_src    = win;
                    m_price  = bus.req_price[win*32 +: 32];
                    m_qty    = bus.req_qty[win*32 +: 32];
                    m_side   = bus.req_side[win];
                    m_reason = bus.req_reason[win*8 +: 8];
                    m_ptr    = (win + 1) % N;
                end
                1: m_phase = rej ? 0 : 2;
                default: if (bus.out_ready) m_phase = 0;
            endcase
            granted_last = exp_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.halt      = 1'b0;
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_tokens", bus.tokens_avail, MAXT);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic present(input int s, input bit side, input logic [31:0] qty, input logic [31:0] price);
        bus.req_price[s*32 +: 32] = price;
        bus.req_qty[s*32 +: 32]   = qty;
        bus.req_side[s]           = side;
        bus.req_reason[s*8 +: 8]  = 8'(s + 64);
        bus.req_valid[s]          = 1'b1;
    endtask

    task automatic take(input int s);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            #1;
            if (bus.req_ready[s]) got = 1'b1;
            step();
        end
        bus.req_valid[s] = 1'b0;
        chk("grant_seen", got, 1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            #1;
            if (!bus.busy) idle = 1'b1;
            else step();
        end
        chk("idle_seen", idle, 1);
    endtask

    task automatic new_order(input int s);
        logic [31:0] q;
        case ($urandom_range(0, 7))
            0:       q = '0;
            1:       q = 32'($urandom_range(300000, 900000));
            default: q = 32'($urandom_range(1, 5000));
        endcase
        present(s, 1'($urandom_range(0, 1)), q, 32'($urandom));
        bus.req_reason[s*8 +: 8] = 8'($urandom);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int idx, n, n_at30, edge9;
        int seq[4];
        bus.req_valid = '0; bus.req_price = '0; bus.req_qty = '0;
        bus.req_side = '0; bus.req_reason = '0; bus.halt = 1'b0; bus.out_ready = 1'b0;

        // single buy from source 0
        reset();
        bus.out_ready = 1'b1;
        present(0, 1'b0, 32'd100, 32'h1000);
        #1;
        chk("t1_ready", bus.req_ready, 1);
        step();
        bus.req_valid[0] = 1'b0;
        chk("t1_check_no_valid", bus.out_valid, 0);
        step();
        chk("t1_out_valid", bus.out_valid, 1);
        chk("t1_out_src", bus.out_src, 0);
        chk("t1_out_price", bus.out_price, 32'h1000);
        step();
        chk("t1_net_position", $signed(bus.net_position), 100);
        chk("t1_tokens", bus.tokens_avail, 7);

        // round robin over three persistent requesters
        reset();
        present(0, 1'b0, 32'd10, 32'd1);
        present(1, 1'b0, 32'd10, 32'd2);
        present(2, 1'b0, 32'd10, 32'd3);
        n = 0;
        for (int i = 0; i < 30 && n < 4; i++) begin
            #1;
            if (bus.req_ready != '0) begin
                idx = 0;
                for (int b = 0; b < N; b++) if (bus.req_ready[b]) idx = b;
                seq[n] = idx;
                n++;
            end
            step();
        end
        bus.req_valid = '0;
        chk("rr_grants", n, 4);
        chk("rr_first", seq[0], 0);
        chk("rr_second", seq[1], 1);
        chk("rr_third", seq[2], 2);
        chk("rr_fourth", seq[3], 0);
        wait_idle();

        // position limit: reject then accept in the other direction
        reset();
        bus.out_ready = 1'b1;
        present(0, 1'b0, 32'd999950, 32'd5);
        take(0);
        step(); step();
        chk("t3_pos_near_limit", $signed(bus.net_position), 999950);
        present(1, 1'b0, 32'd100, 32'd6);
        take(1);
        chk("t3_reject_valid", bus.reject_valid, 1);
        chk("t3_reject_src", bus.reject_src, 1);
        chk("t3_no_out_valid", bus.out_valid, 0);
        step();
        chk("t3_reject_pulse_end", bus.reject_valid, 0);
        chk("t3_pos_unchanged", $signed(bus.net_position), 999950);
        chk("t3_tokens_unchanged", bus.tokens_avail, 7);
        present(2, 1'b1, 32'd100, 32'd7);
        take(2);
        step(); step();
        chk("t3_pos_after_sell", $signed(bus.net_position), 999850);

        // token exhaustion: ninth order waits for the first refill
        reset();
        bus.out_ready = 1'b1;
        present(0, 1'b0, 32'd1, 32'd9);
        n = 0; n_at30 = -1; edge9 = -1;
        for (int c = 0; c < 80 && n < 9; c++) begin
            #1;
            if (c == 30) begin
                n_at30 = n;
                chk("t4_tokens_empty", bus.tokens_avail, 0);
                chk("t4_stalled", bus.req_ready, 0);
            end
            if (bus.req_ready[0]) begin
                n++;
                if (n == 9) edge9 = c + 1;
            end
            step();
        end
        bus.req_valid = '0;
        chk("t4_grants_before_refill", n_at30, 8);
        chk("t4_ninth_grant_cycle", edge9, 51);
        wait_idle();

        // halt does not withdraw an issued order but blocks new grants
        reset();
        bus.out_ready = 1'b0;
        present(3, 1'b1, 32'd500, 32'd11);
        take(3);
        step();
        chk("t5_issue", bus.out_valid, 1);
        bus.halt = 1'b1;
        present(0, 1'b0, 32'd7, 32'd12);
        repeat (3) begin
            step();
            chk("t5_held_valid", bus.out_valid, 1);
            chk("t5_held_src", bus.out_src, 3);
        end
        bus.out_ready = 1'b1;
        step();
        chk("t5_accepted", bus.out_valid, 0);
        repeat (5) begin
            #1;
            chk("t5_halt_no_grant", bus.req_ready, 0);
            chk("t5_halt_idle", bus.busy, 0);
            step();
        end
        bus.halt = 1'b0;
        #1;
        chk("t5_resume_grant", bus.req_ready, 1);
        take(0);
        step(); step();
        chk("t5_net_position", $signed(bus.net_position), -493);

        // asynchronous reset during ISSUE
        bus.out_ready = 1'b0;
        present(1, 1'b0, 32'd20, 32'd13);
        take(1);
        step();
        chk("t6_issue", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid_cleared", bus.out_valid, 0);
        chk("t6_pos_cleared", $signed(bus.net_position), 0);
        chk("t6_tokens_full", bus.tokens_avail, MAXT);
        chk("t6_busy_cleared", bus.busy, 0);
        reset();

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int s = 0; s < N; s++) begin
                if (bus.req_valid[s] && granted_last[s]) begin
                    if ($urandom_range(0, 1) == 1) new_order(s);
                    else bus.req_valid[s] = 1'b0;
                end else if (!bus.req_valid[s] && $urandom_range(0, 3) == 0) begin
                    new_order(s);
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.halt      = ($urandom_range(0, 31) == 0);
        end
        bus.req_valid = '0;
        bus.halt      = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
